// File: rtl/accu_group.sv
// Group accumulator: sums GROUP_N accepted samples and emits each total through a
// registered valid/ready output, with early flush and a selectable input-gap policy.
module accu_group #(
    parameter int  DATA_W   = 8,
    parameter int  GROUP_N  = 4,
    parameter int  GAP_MODE = 0,
    localparam int OUT_W    = DATA_W + $clog2(GROUP_N),
    localparam int CNT_W    = $clog2(GROUP_N + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic              flush,
    output logic [OUT_W-1:0]  data_out,
    output logic [CNT_W-1:0]  count_out,
    output logic              valid_out,
    input  logic              ready_out
);

    logic [OUT_W-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [OUT_W-1:0] data_q,  data_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic             flush_eff;
    logic             load;
    logic [OUT_W-1:0] sum;
    logic [CNT_W-1:0] cnt_inc;

    // A full output register frees up in the same cycle the consumer takes it.
    assign ready_in  = !valid_q || ready_out;
    assign accept    = valid_in && ready_in;
    assign flush_eff = flush && ready_in;
    assign sum       = acc_q + OUT_W'(data_in);
    assign cnt_inc   = cnt_q + CNT_W'(1);

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        count_d = count_q;
        load    = 1'b0;

        if (accept) begin
            if (cnt_inc == CNT_W'(GROUP_N) || flush_eff) begin
                data_d  = sum;
                count_d = cnt_inc;
                acc_d   = '0;
                cnt_d   = '0;
                load    = 1'b1;
            end else begin
                acc_d = sum;
                cnt_d = cnt_inc;
            end
        end else if (flush_eff && cnt_q != '0) begin
            data_d  = acc_q;
            count_d = cnt_q;
            acc_d   = '0;
            cnt_d   = '0;
            load    = 1'b1;
        end else if (GAP_MODE == 1 && ready_in && !valid_in && cnt_q != '0) begin
            // A stalled cycle is not a gap, hence the ready_in qualifier.
            acc_d = '0;
            cnt_d = '0;
        end

        valid_d = load || (valid_q && !ready_out);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all of them update together.
        if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign count_out = count_q;
    assign valid_out = valid_q;

endmodule
